// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width, rx FIFO sizing and the stored entry layout.
package uart_pkg;

    localparam int UART_N        = 8;
    localparam int RXFIFO_DEPTH  = 8;
    localparam int RXFIFO_THRESH = 4;

    typedef struct packed {
        logic              err;
        logic [UART_N-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around FIFO pointer with increment enable and synchronous clear; shared by rx and tx FIFOs.
module fifo_ptr #(
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Natural binary overflow gives the modulo-DEPTH wrap for power-of-two depths.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side circular FIFO: captures {err,data} on each rising edge of rx_done and presents
// the head entry show-ahead, with occupancy, threshold interrupt and sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int N      = UART_N,
    parameter int DEPTH  = RXFIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH),
    parameter int THRESH = RXFIFO_THRESH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          rx_done,
    input  logic          rx_err,
    input  logic [N-1:0]  rx_data,
    input  logic          rd_en,
    output logic [N-1:0]  rd_data,
    output logic          rd_err,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          level_irq,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW:0] THRESH_C = THRESH[AW:0];

    logic          done_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          irq_q;
    logic          irq_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [N:0]    mem [DEPTH];
    logic [N:0]    head;

    logic push_req;
    logic empty_s;
    logic full_s;
    logic pop;
    logic push_acc;
    logic ovf_set;

    always_comb begin
        push_req = rx_done & ~done_q;
        empty_s  = (count_q == '0);
        full_s   = (count_q == DEPTH_C);
        pop      = rd_en & ~empty_s & ~flush;
        // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
        push_acc = push_req & (~full_s | pop) & ~flush;
        ovf_set  = push_req & full_s & ~pop & ~flush;

        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_acc) begin
            count_d = count_q - 1'b1;
        end

        irq_d = (count_d >= THRESH_C);
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            done_q  <= rx_done;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= {rx_err, rx_data};
        end
    end

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (flush),
        .en_i  (push_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (flush),
        .en_i  (pop),
        .ptr_o (rd_ptr)
    );

    assign head      = mem[rd_ptr];
    assign rd_data   = empty_s ? '0 : head[N-1:0];
    assign rd_err    = empty_s ? 1'b0 : head[N];
    assign empty     = empty_s;
    assign full      = full_s;
    assign count     = count_q;
    assign level_irq = irq_q;
    assign ovf       = ovf_q;

endmodule
